systolic_result_drain: RTL and testbench

- Downstream stage of the 16x16 systolic matrix multiplier.
- Snapshots the multiplier's flattened result matrix C_flat when the multiplier signals done.
- Serialises the snapshot row-major onto a valid/ready element stream carrying row/column tags, so consumers such as a writeback DMA or scoreboard never touch the 8192-bit bus.
- Counts result frames that arrive while a previous frame is still draining.

---
 rtl/systolic_result_drain.sv | 62 ++++++
 tb/tb_systolic_result_drain.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_result_drain.sv
// systolic_result_drain: snapshots the multiplier result matrix on a done edge and streams it row-major as tagged elements
// Ports: clk; rst (async, active-low); mm_done/C_flat from the multiplier;
//   out_valid/out_ready/out_data/out_row/out_col/out_last element stream;
//   busy (frame buffered or draining); drain_done (pulse after the last beat);
//   drop_count (saturating count of frames that arrived while busy).
module systolic_result_drain #(
  parameter int WIDTH = 16,
  parameter int MATRIX_SIZE = 16,
  parameter int IDX_W = $clog2(MATRIX_SIZE)
) (
  input  logic clk,
  input  logic rst,
  input  logic mm_done,
  input  logic [2*WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] C_flat,
  output logic out_valid,
  input  logic out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_row,
  output logic [IDX_W-1:0] out_col,
  output logic out_last,
  output logic busy,
  output logic drain_done,
  output logic [7:0] drop_count
);
  localparam int EW = 2*WIDTH;
  localparam int NE = MATRIX_SIZE*MATRIX_SIZE;
  localparam int CW = $clog2(NE);
  localparam logic [1:0] IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic mm_done_q;
  logic [CW-1:0] idx;
  logic [EW-1:0] mem [NE];
  logic trig, hs, at_last;
  assign trig = mm_done && !mm_done_q;
  assign hs = out_valid && out_ready;
  assign at_last = idx == CW'(NE-1);
  assign out_valid = state == STREAM;
  assign out_data = out_valid ? mem[idx] : '0;
  // power-of-two N: the flat index splits directly into row (upper bits) and column (lower bits)
  assign out_row = idx[CW-1 -: IDX_W];
  assign out_col = idx[IDX_W-1:0];
  assign out_last = out_valid && at_last;
  assign busy = state != IDLE;
  assign drain_done = state == DONE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      mm_done_q <= 1'b0;
      idx <= '0;
      drop_count <= '0;
    end else begin
      mm_done_q <= mm_done;
      state <= state == IDLE ? (trig ? STREAM : IDLE) :
               state == STREAM ? (hs && at_last ? DONE : STREAM) : IDLE;
      idx <= state == IDLE ? '0 : idx + CW'(hs);
      drop_count <= drop_count + 8'(trig && state != IDLE && drop_count != 8'hff);
    end
  // snapshot buffer carries no reset; it is only read while streaming a captured frame
  always_ff @(posedge clk)
    if (rst && state == IDLE && trig)
      for (int k = 0; k < NE; k++) mem[k] <= C_flat[EW*k +: EW];
endmodule

// File: tb/tb_systolic_result_drain.sv
// tb_systolic_result_drain: scoreboard bench for systolic_result_drain
module tb_systolic_result_drain;
  localparam int N = 16;
  localparam int EW = 32;
  localparam int NE = N*N;
  typedef struct {logic [31:0] d; logic [3:0] r; logic [3:0] c; logic l;} exp_t;
  logic clk = 1'b0;
  logic rst, mm_done, out_ready;
  logic [EW*NE-1:0] c_flat;
  logic out_valid, out_last, busy, drain_done;
  logic [EW-1:0] out_data;
  logic [3:0] out_row, out_col;
  logic [7:0] drop_count;
  exp_t q[$];
  exp_t e;
  int errors = 0, checks = 0, beats = 0, mode = 0, ph = 0;
  always #5 clk = ~clk;
  systolic_result_drain #(.WIDTH(16), .MATRIX_SIZE(N)) dut (
    .clk(clk), .rst(rst), .mm_done(mm_done), .C_flat(c_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_last(out_last),
    .busy(busy), .drain_done(drain_done), .drop_count(drop_count)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  // ready driver: 0 = always ready, 1 = 1-0-0 pattern, 2 = never ready
  always begin
    @(posedge clk);
    #2;
    if (mode == 0) out_ready = 1'b1;
    else if (mode == 1) begin
      out_ready = (ph == 0);
      ph = (ph == 2) ? 0 : ph + 1;
    end else out_ready = 1'b0;
  end
  // monitor: every presented element must match the scoreboard head; pop on handshake
  always @(negedge clk)
    if (rst && out_valid) begin
      if (q.size() == 0) chk("unexpected_valid", out_valid, 0);
      else begin
        e = q[0];
        chk("data", out_data, e.d);
        chk("row", out_row, e.r);
        chk("col", out_col, e.c);
        chk("last", out_last, e.l);
        if (out_ready) begin
          void'(q.pop_front());
          beats++;
        end
      end
    end
  task automatic set_flat(input bit sevens);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        c_flat[EW*(N*i+j) +: EW] = sevens ? 32'd7 : 32'(i+j);
  endtask
  task automatic push_frame(input bit sevens);
    exp_t x;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        x.d = sevens ? 32'd7 : 32'(i+j);
        x.r = 4'(i);
        x.c = 4'(j);
        x.l = (i == N-1 && j == N-1);
        q.push_back(x);
      end
  endtask
  task automatic trigger(input bit sevens);
    @(posedge clk);
    #1;
    mm_done = 1'b1;
    ph = 2;
    push_frame(sevens);
    @(posedge clk);
    @(negedge clk);
    chk("first_valid", out_valid, 1);
    chk("first_busy", busy, 1);
  endtask
  task automatic lower;
    @(posedge clk);
    #1;
    mm_done = 1'b0;
  endtask
  task automatic wait_beats(input int n);
    int b, k;
    b = beats;
    k = 0;
    while (beats < b + n && k < 2000) begin
      @(posedge clk);
      k++;
    end
    chk("beat_timeout", beats >= b + n, 1);
  endtask
  task automatic wait_done(input int lim, input int exp_n, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!drain_done && n < lim);
    chk("drain_seen", drain_done, 1);
    if (exp_n >= 0) chk(name, n, exp_n);
    chk("done_busy", busy, 1);
    chk("done_valid", out_valid, 0);
    chk("queue_empty", q.size(), 0);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("pulse_one", drain_done, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b0;
    mm_done = 1'b0;
    out_ready = 1'b0;
    set_flat(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drain", drain_done, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_data", out_data, 0);
    chk("rst_row", out_row, 0);
    chk("rst_col", out_col, 0);
    chk("rst_last", out_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    trigger(0);
    wait_done(1000, 256, "cycles_ready1");
    lower();
    mode = 1;
    trigger(0);
    wait_done(2000, 766, "cycles_stall");
    chk("stall_drop", drop_count, 0);
    lower();
    mode = 0;
    trigger(0);
    wait_done(1000, 256, "cycles_held");
    repeat (244) @(posedge clk);
    @(negedge clk);
    chk("held_drop", drop_count, 0);
    chk("held_busy", busy, 0);
    lower();
    trigger(0);
    wait_beats(100);
    lower();
    set_flat(1);
    @(posedge clk);
    #1;
    mm_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("drop_one", drop_count, 1);
    chk("drop_busy", busy, 1);
    wait_done(1000, -1, "");
    chk("drop_one_after", drop_count, 1);
    lower();
    trigger(1);
    wait_done(1000, 256, "cycles_sevens");
    lower();
    set_flat(0);
    trigger(0);
    wait_beats(50);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_row", out_row, 0);
    chk("abort_col", out_col, 0);
    chk("abort_drain", drain_done, 0);
    chk("abort_drop", drop_count, 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_nodrain", drain_done, 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    mm_done = 1'b0;
    trigger(0);
    wait_done(1000, 256, "cycles_restart");
    lower();
    mode = 2;
    trigger(0);
    repeat (255) begin
      lower();
      @(posedge clk);
      #1;
      mm_done = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("drop_255", drop_count, 255);
    repeat (45) begin
      lower();
      @(posedge clk);
      #1;
      mm_done = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("drop_sat", drop_count, 255);
    chk("stalled_valid", out_valid, 1);
    mode = 0;
    wait_done(1000, -1, "");
    chk("drop_sat_after", drop_count, 255);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
